// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone arbiter, M1 priority with starvation guard.
// Per-beat watchdog completes any beat the slave never acknowledges.
module wb_bus_arbiter #(
  parameter int MAX_M1_RUN = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] m0_adr_i,
  input  logic [1:0]  m0_tga_i,
  input  logic [7:0]  m0_dat_i,
  output logic [7:0]  m0_dat_o,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [15:0] m1_adr_i,
  input  logic [1:0]  m1_tga_i,
  input  logic [7:0]  m1_dat_i,
  output logic [7:0]  m1_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [15:0] s_adr_o,
  output logic [1:0]  s_tga_o,
  output logic [7:0]  s_dat_o,
  input  logic [7:0]  s_dat_i,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  localparam logic [3:0] RUN_MAX = 4'(MAX_M1_RUN);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [3:0] run_cnt, run_nxt;
  logic [7:0] wd_cnt, wd_nxt;
  logic       own_stb;
  logic       tmo;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      run_cnt <= '0;
      wd_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_nxt;
      wd_cnt  <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    unique case (state)
      IDLE: begin
        if (m1_cyc_i && (run_cnt < RUN_MAX || !m0_cyc_i)) begin
          state_nxt = OWN1;
          run_nxt   = m0_cyc_i ? run_cnt + 4'd1 : 4'd0;
        end else if (m0_cyc_i) begin
          state_nxt = OWN0;
          run_nxt   = '0;
        end
      end
      OWN0:    if (!m0_cyc_i) state_nxt = IDLE;
      OWN1:    if (!m1_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_adr_o = '0;
    s_tga_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    own_stb = 1'b0;
    unique case (state)
      OWN0: begin
        s_adr_o = m0_adr_i;
        s_tga_o = m0_tga_i;
        s_dat_o = m0_dat_i;
        s_we_o  = m0_we_i;
        s_cyc_o = m0_cyc_i;
        own_stb = m0_stb_i;
      end
      OWN1: begin
        s_adr_o = m1_adr_i;
        s_tga_o = m1_tga_i;
        s_dat_o = m1_dat_i;
        s_we_o  = m1_we_i;
        s_cyc_o = m1_cyc_i;
        own_stb = m1_stb_i;
      end
      default: ;
    endcase
  end

  // A real ack in the timeout cycle wins over the forced termination.
  assign tmo = !rst_i && own_stb && !s_ack_i && wd_cnt == WD_LAST;

  always_comb begin
    wd_nxt = wd_cnt;
    if (state_nxt != state || s_ack_i || tmo)
      wd_nxt = '0;
    else if (own_stb)
      wd_nxt = wd_cnt + 8'd1;
  end

  assign s_stb_o = own_stb && !tmo;
  assign gnt_o   = {state == OWN1, state == OWN0};

  assign m0_ack_o = !rst_i && state == OWN0 &&
                    ((s_ack_i && m0_stb_i) || tmo);
  assign m1_ack_o = !rst_i && state == OWN1 &&
                    ((s_ack_i && m1_stb_i) || tmo);
  assign m0_err_o = tmo && state == OWN0;
  assign m1_err_o = tmo && state == OWN1;

  assign m0_dat_o = m0_err_o ? 8'hFF : s_dat_i;
  assign m1_dat_o = m1_err_o ? 8'hFF : s_dat_i;

endmodule
